// File: rtl/pi_aim_ramp.sv
// Setpoint conditioner for a PI controller: decimates sample strobes, slews the aim toward
// the target by at most STEP per accepted sample, and supports bumpless aim-to-measurement sync.
module pi_aim_ramp #(
   parameter logic [15:0] STEP = 16'd64,
   parameter logic [7:0]  DIV  = 8'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   input  logic [15:0] i_real,
   input  logic [15:0] i_target,
   input  logic        i_sync,
   output logic        o_en,
   output logic [15:0] o_aim,
   output logic [15:0] o_real,
   output logic        o_settled
);

   typedef enum logic [1:0] {
      ST_SETTLED = 2'd0,
      ST_RAMPING = 2'd1,
      ST_SYNCED  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        sync_q, sync_d;
   logic [15:0] aim_q, aim_d;
   logic [15:0] real_q, real_d;
   logic        en_q, en_d;
   logic        settled_q, settled_d;

   logic               accept_s;
   logic signed [16:0] step_s;
   logic signed [16:0] aim_ext_s;
   logic signed [16:0] diff_s;
   logic signed [16:0] aim_up_s;
   logic signed [16:0] aim_dn_s;

   // Aim only ever moves toward a 16-bit target, so the 17-bit sums always fit back in 16 bits.
   assign accept_s  = i_en && (cnt_q == (DIV - 8'd1));
   assign step_s    = $signed({1'b0, STEP});
   assign aim_ext_s = $signed({aim_q[15], aim_q});
   assign diff_s    = $signed({i_target[15], i_target}) - aim_ext_s;
   assign aim_up_s  = aim_ext_s + step_s;
   assign aim_dn_s  = aim_ext_s - step_s;

   // Next-state: decimation counter, sync flag, slew step, state and output payload.
   always_comb begin
      cnt_d     = cnt_q;
      sync_d    = sync_q | i_sync;
      state_d   = state_q;
      aim_d     = aim_q;
      real_d    = real_q;
      en_d      = 1'b0;
      settled_d = settled_q;

      if (i_en) begin
         if (accept_s) begin
            cnt_d = 8'd0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end

      if (accept_s) begin
         en_d   = 1'b1;
         real_d = i_real;
         sync_d = 1'b0;
         if (sync_q || i_sync) begin
            aim_d   = i_real;
            state_d = ST_SYNCED;
         end else begin
            if (diff_s > step_s) begin
               aim_d = aim_up_s[15:0];
            end else if (diff_s < -step_s) begin
               aim_d = aim_dn_s[15:0];
            end else begin
               aim_d = i_target;
            end
            state_d = (aim_d == i_target) ? ST_SETTLED : ST_RAMPING;
         end
         case (state_d)
            ST_SETTLED: settled_d = 1'b1;
            ST_RAMPING: settled_d = 1'b0;
            ST_SYNCED:  settled_d = (aim_d == i_target);
            default:    settled_d = 1'b1;
         endcase
      end else begin
         settled_d = settled_q;
      end
   end

   // State and output registers, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_SETTLED;
         cnt_q     <= 8'd0;
         sync_q    <= 1'b0;
         aim_q     <= 16'd0;
         real_q    <= 16'd0;
         en_q      <= 1'b0;
         settled_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sync_q    <= sync_d;
         aim_q     <= aim_d;
         real_q    <= real_d;
         en_q      <= en_d;
         settled_q <= settled_d;
      end
   end

   assign o_en      = en_q;
   assign o_aim     = aim_q;
   assign o_real    = real_q;
   assign o_settled = settled_q;

endmodule

// File: tb/tb_pi_aim_ramp.sv
// Directed testbench for pi_aim_ramp: three instances (STEP/DIV variants) share one stimulus bus.
module tb_pi_aim_ramp;

   logic        clk;
   logic        rst;
   logic        i_en;
   logic        i_sync;
   logic [15:0] i_real;
   logic [15:0] i_target;

   logic               en_a, set_a, en_d, set_d, en_x, set_x;
   logic signed [15:0] aim_a, real_a, aim_d, real_d, aim_x, real_x;

   int errors;
   int checks;

   pi_aim_ramp #(.STEP(16'd64), .DIV(8'd1)) dut_a (
      .clk(clk), .rst(rst), .i_en(i_en), .i_real(i_real), .i_target(i_target), .i_sync(i_sync),
      .o_en(en_a), .o_aim(aim_a), .o_real(real_a), .o_settled(set_a));

   pi_aim_ramp #(.STEP(16'd64), .DIV(8'd3)) dut_d (
      .clk(clk), .rst(rst), .i_en(i_en), .i_real(i_real), .i_target(i_target), .i_sync(i_sync),
      .o_en(en_d), .o_aim(aim_d), .o_real(real_d), .o_settled(set_d));

   pi_aim_ramp #(.STEP(16'd32767), .DIV(8'd1)) dut_x (
      .clk(clk), .rst(rst), .i_en(i_en), .i_real(i_real), .i_target(i_target), .i_sync(i_sync),
      .o_en(en_x), .o_aim(aim_x), .o_real(real_x), .o_settled(set_x));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One strobe; returns on the following negedge where that strobe's outputs are visible.
   task automatic do_strobe(input logic signed [15:0] tgt, input logic signed [15:0] rl, input logic sy);
      @(negedge clk);
      i_en = 1'b1; i_target = tgt; i_real = rl; i_sync = sy;
      @(negedge clk);
      i_en = 1'b0; i_sync = 1'b0;
   endtask

   task automatic apply_reset;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b expected 0", en_a); end
      checks++; if (aim_a !== 16'sd0) begin errors++; $display("FAIL reset_aim: got %0d expected 0", aim_a); end
      checks++; if (real_a !== 16'sd0) begin errors++; $display("FAIL reset_real: got %0d expected 0", real_a); end
      checks++; if (set_a !== 1'b1) begin errors++; $display("FAIL reset_settled: got %0b expected 1", set_a); end
      checks++; if (set_d !== 1'b1 || en_d !== 1'b0) begin errors++; $display("FAIL reset_div: got en=%0b set=%0b expected en=0 set=1", en_d, set_d); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_ramp_up;
      logic signed [15:0] exp_aim [5] = '{16'sd64, 16'sd128, 16'sd192, 16'sd256, 16'sd300};
      for (int i = 0; i < 5; i++) begin
         do_strobe(16'sd300, 16'(i * 7), 1'b0);
         checks++; if (en_a !== 1'b1) begin errors++; $display("FAIL ramp_up_en[%0d]: got %0b expected 1", i, en_a); end
         checks++; if (aim_a !== exp_aim[i]) begin errors++; $display("FAIL ramp_up_aim[%0d]: got %0d expected %0d", i, aim_a, exp_aim[i]); end
         checks++; if (set_a !== (i == 4)) begin errors++; $display("FAIL ramp_up_settled[%0d]: got %0b expected %0b", i, set_a, (i == 4)); end
         checks++; if (real_a !== 16'(i * 7)) begin errors++; $display("FAIL ramp_up_real[%0d]: got %0d expected %0d", i, real_a, i * 7); end
      end
      @(negedge clk);
      checks++; if (en_a !== 1'b0 || aim_a !== 16'sd300) begin errors++; $display("FAIL ramp_up_hold: got en=%0b aim=%0d expected en=0 aim=300", en_a, aim_a); end
   endtask

   task automatic test_ramp_down;
      do_strobe(-16'sd100, 16'sd0, 1'b0);
      checks++; if (aim_a !== 16'sd236 || set_a !== 1'b0) begin errors++; $display("FAIL ramp_down_1: got aim=%0d set=%0b expected aim=236 set=0", aim_a, set_a); end
      do_strobe(-16'sd100, 16'sd0, 1'b0);
      checks++; if (aim_a !== 16'sd172 || set_a !== 1'b0) begin errors++; $display("FAIL ramp_down_2: got aim=%0d set=%0b expected aim=172 set=0", aim_a, set_a); end
      do_strobe(16'sd200, 16'sd0, 1'b0);
      checks++; if (aim_a !== 16'sd200 || set_a !== 1'b1) begin errors++; $display("FAIL retarget: got aim=%0d set=%0b expected aim=200 set=1", aim_a, set_a); end
   endtask

   task automatic test_back_to_back;
      logic signed [15:0] exp_aim [4] = '{16'sd264, 16'sd328, 16'sd392, 16'sd456};
      @(negedge clk);
      i_en = 1'b1; i_target = 16'sd1000; i_real = 16'sd0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 3) i_en = 1'b0;
         checks++; if (en_a !== 1'b1 || aim_a !== exp_aim[k]) begin errors++; $display("FAIL b2b[%0d]: got en=%0b aim=%0d expected en=1 aim=%0d", k, en_a, aim_a, exp_aim[k]); end
      end
      @(negedge clk);
      checks++; if (en_a !== 1'b0 || aim_a !== 16'sd456) begin errors++; $display("FAIL b2b_end: got en=%0b aim=%0d expected en=0 aim=456", en_a, aim_a); end
   endtask

   task automatic test_decimation;
      apply_reset();
      for (int n = 1; n <= 9; n++) begin
         do_strobe(16'sd300, 16'(n), 1'b0);
         checks++; if (en_d !== (n % 3 == 0)) begin errors++; $display("FAIL decim_en[%0d]: got %0b expected %0b", n, en_d, (n % 3 == 0)); end
         if (n % 3 == 0) begin
            checks++; if (aim_d !== 16'(64 * (n / 3)) || real_d !== 16'(n)) begin errors++; $display("FAIL decim_out[%0d]: got aim=%0d real=%0d expected aim=%0d real=%0d", n, aim_d, real_d, 64 * (n / 3), n); end
         end
      end
      @(negedge clk);
      checks++; if (en_d !== 1'b0) begin errors++; $display("FAIL decim_pulse: got %0b expected 0", en_d); end
   endtask

   task automatic test_sync;
      apply_reset();
      @(negedge clk); i_sync = 1'b1;
      @(negedge clk); i_sync = 1'b0;
      @(negedge clk); i_sync = 1'b1;
      @(negedge clk); i_sync = 1'b0;
      checks++; if (en_a !== 1'b0 || aim_a !== 16'sd0) begin errors++; $display("FAIL sync_idle: got en=%0b aim=%0d expected en=0 aim=0", en_a, aim_a); end
      do_strobe(16'sd5000, -16'sd1234, 1'b0);
      checks++; if (aim_a !== -16'sd1234 || set_a !== 1'b0 || real_a !== -16'sd1234) begin errors++; $display("FAIL sync_load: got aim=%0d set=%0b real=%0d expected aim=-1234 set=0 real=-1234", aim_a, set_a, real_a); end
      do_strobe(16'sd5000, 16'sd77, 1'b0);
      checks++; if (aim_a !== -16'sd1170 || set_a !== 1'b0 || real_a !== 16'sd77) begin errors++; $display("FAIL sync_next: got aim=%0d set=%0b real=%0d expected aim=-1170 set=0 real=77", aim_a, set_a, real_a); end
      do_strobe(16'sd5000, 16'sd42, 1'b1);
      checks++; if (aim_a !== 16'sd42 || set_a !== 1'b0) begin errors++; $display("FAIL sync_same_cycle: got aim=%0d set=%0b expected aim=42 set=0", aim_a, set_a); end
      do_strobe(16'sd42, 16'sd9, 1'b0);
      checks++; if (aim_a !== 16'sd42 || set_a !== 1'b1) begin errors++; $display("FAIL sync_resolve: got aim=%0d set=%0b expected aim=42 set=1", aim_a, set_a); end
      do_strobe(-16'sd7, -16'sd7, 1'b1);
      checks++; if (aim_a !== -16'sd7 || set_a !== 1'b1) begin errors++; $display("FAIL sync_on_target: got aim=%0d set=%0b expected aim=-7 set=1", aim_a, set_a); end
   endtask

   task automatic test_extremes;
      logic signed [15:0] exp_up [3] = '{-16'sd1, 16'sd32766, 16'sd32767};
      logic signed [15:0] exp_dn [3] = '{16'sd0, -16'sd32767, -16'sd32768};
      do_strobe(16'sd32767, -16'sd32768, 1'b1);
      checks++; if (aim_x !== -16'sd32768 || set_x !== 1'b0) begin errors++; $display("FAIL ext_sync: got aim=%0d set=%0b expected aim=-32768 set=0", aim_x, set_x); end
      for (int i = 0; i < 3; i++) begin
         do_strobe(16'sd32767, 16'sd0, 1'b0);
         checks++; if (aim_x !== exp_up[i] || set_x !== (i == 2)) begin errors++; $display("FAIL ext_up[%0d]: got aim=%0d set=%0b expected aim=%0d set=%0b", i, aim_x, set_x, exp_up[i], (i == 2)); end
      end
      for (int i = 0; i < 3; i++) begin
         do_strobe(-16'sd32768, 16'sd0, 1'b0);
         checks++; if (aim_x !== exp_dn[i] || set_x !== (i == 2)) begin errors++; $display("FAIL ext_dn[%0d]: got aim=%0d set=%0b expected aim=%0d set=%0b", i, aim_x, set_x, exp_dn[i], (i == 2)); end
      end
   endtask

   task automatic test_reset_mid;
      apply_reset();
      do_strobe(16'sd1000, 16'sd3, 1'b0);
      do_strobe(16'sd1000, 16'sd3, 1'b0);
      checks++; if (aim_a !== 16'sd128) begin errors++; $display("FAIL pre_reset_aim: got %0d expected 128", aim_a); end
      @(negedge clk); i_sync = 1'b1;
      @(negedge clk); i_sync = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++; if (en_a !== 1'b0 || aim_a !== 16'sd0 || real_a !== 16'sd0 || set_a !== 1'b1) begin errors++; $display("FAIL async_reset: got en=%0b aim=%0d real=%0d set=%0b expected 0/0/0/1", en_a, aim_a, real_a, set_a); end
      @(negedge clk); rst = 1'b0;
      do_strobe(16'sd10, 16'sd5, 1'b0);
      checks++; if (en_a !== 1'b1 || aim_a !== 16'sd10 || set_a !== 1'b1 || real_a !== 16'sd5) begin errors++; $display("FAIL post_reset: got en=%0b aim=%0d set=%0b real=%0d expected en=1 aim=10 set=1 real=5", en_a, aim_a, set_a, real_a); end
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      rst      = 1'b1;
      i_en     = 1'b0;
      i_sync   = 1'b0;
      i_real   = 16'd0;
      i_target = 16'd0;
      test_reset();
      test_ramp_up();
      test_ramp_down();
      test_back_to_back();
      test_decimation();
      test_sync();
      test_extremes();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
